// File: rtl/cond_sum_if.sv
`default_nettype none
// ============================================================================
// Module      : cond_sum_if
// Description : Conditional-sum cell bundle interface. The master side is the
//               cell array / result consumer; the slave side is the resolver.
//               Input bundle : in_valid/in_ready, s0_i, s1_i, c0_i, c1_i, cin_i
//               Result       : out_valid/out_ready, sum_o, cout_o, err_o
// Revision    : 1.0 - initial release
// ============================================================================
interface cond_sum_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s0_i;
    logic [WIDTH-1:0] s1_i;
    logic [WIDTH-1:0] c0_i;
    logic [WIDTH-1:0] c1_i;
    logic             cin_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             err_o;

    modport master (
        output in_valid, s0_i, s1_i, c0_i, c1_i, cin_i, out_ready,
        input  in_ready, out_valid, sum_o, cout_o, err_o
    );

    modport slave (
        input  in_valid, s0_i, s1_i, c0_i, c1_i, cin_i, out_ready,
        output in_ready, out_valid, sum_o, cout_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/cond_sum_resolver.sv
`default_nettype none
// ============================================================================
// Module      : cond_sum_resolver
// Description : Pipelined conditional-sum merge stage. Per-bit cell outputs
//               (sum/carry for carry-in 0 and 1) are merged pairwise through
//               log2(WIDTH) registered levels; the last level applies the real
//               carry-in and holds the resolved sum and carry-out.
// Ports       : clk  - clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - cond_sum_if.slave (valid/ready input bundle and
//                      valid/ready result with sticky invariant error flag)
// Revision    : 1.0 - initial release
// ============================================================================
module cond_sum_resolver #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    cond_sum_if.slave  bus
);

    localparam int c_levels = $clog2(WIDTH);

    // ------------------------------------------------------------------------
    // Level registers. Level k (1..c_levels-1) holds WIDTH/2^k blocks; the
    // sums are kept as full WIDTH vectors (blocks concatenated) and the block
    // carries occupy the low WIDTH/2^k bits of the carry vectors. The last
    // level is represented by r_sum / r_cout only.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]      r_sum0 [1:c_levels];
    logic [WIDTH-1:0]      r_sum1 [1:c_levels];
    logic [WIDTH-1:0]      r_c0   [1:c_levels];
    logic [WIDTH-1:0]      r_c1   [1:c_levels];
    logic                  r_cin  [1:c_levels];
    logic [c_levels:1]     r_valid;
    logic [WIDTH-1:0]      r_sum;
    logic                  r_cout;
    logic                  r_err;

    // Source of each level: index 0 is the raw cell bundle, index k is the
    // level-k register.
    logic [WIDTH-1:0]      w_src_sum0 [0:c_levels-1];
    logic [WIDTH-1:0]      w_src_sum1 [0:c_levels-1];
    logic [WIDTH-1:0]      w_src_c0   [0:c_levels-1];
    logic [WIDTH-1:0]      w_src_c1   [0:c_levels-1];
    logic [c_levels-1:0]   w_src_cin;
    logic [c_levels-1:0]   w_src_valid;

    // Merged (not yet registered) data for each level.
    logic [WIDTH-1:0]      w_m_sum0 [1:c_levels];
    logic [WIDTH-1:0]      w_m_sum1 [1:c_levels];
    logic [WIDTH-1:0]      w_m_c0   [1:c_levels];
    logic [WIDTH-1:0]      w_m_c1   [1:c_levels];

    logic [c_levels:1]     w_load;
    logic                  w_accept;
    logic                  w_violation;
    logic [WIDTH-1:0]      w_res_sum;
    logic                  w_res_cout;

    // ------------------------------------------------------------------------
    // Level sources
    // ------------------------------------------------------------------------
    always_comb begin
        w_src_sum0[0]  = bus.s0_i;
        w_src_sum1[0]  = bus.s1_i;
        w_src_c0[0]    = bus.c0_i;
        w_src_c1[0]    = bus.c1_i;
        w_src_cin[0]   = bus.cin_i;
        w_src_valid[0] = bus.in_valid;
        for (int k = 1; k < c_levels; k++) begin
            w_src_sum0[k]  = r_sum0[k];
            w_src_sum1[k]  = r_sum1[k];
            w_src_c0[k]    = r_c0[k];
            w_src_c1[k]    = r_c1[k];
            w_src_cin[k]   = r_cin[k];
            w_src_valid[k] = r_valid[k];
        end
    end

    // ------------------------------------------------------------------------
    // Pairwise block merge. At level k a bit in the upper half of its 2^k
    // block selects the carry-in-1 sum of the high sub-block whenever the low
    // sub-block carries out (separately for the cin=0 and cin=1 hypotheses);
    // bits in the lower half pass through. Low sub-block index in the
    // previous level is (bit >> k) * 2.
    // ------------------------------------------------------------------------
    always_comb begin
        for (int k = 1; k <= c_levels; k++) begin
            w_m_sum0[k] = '0;
            w_m_sum1[k] = '0;
            w_m_c0[k]   = '0;
            w_m_c1[k]   = '0;
        end
        for (int k = 1; k <= c_levels; k++) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (((b >> (k - 1)) & 1) != 0) begin
                    w_m_sum0[k][b] = w_src_c0[k-1][(b >> k) << 1]
                                   ? w_src_sum1[k-1][b] : w_src_sum0[k-1][b];
                    w_m_sum1[k][b] = w_src_c1[k-1][(b >> k) << 1]
                                   ? w_src_sum1[k-1][b] : w_src_sum0[k-1][b];
                end else begin
                    w_m_sum0[k][b] = w_src_sum0[k-1][b];
                    w_m_sum1[k][b] = w_src_sum1[k-1][b];
                end
            end
            for (int j = 0; j < WIDTH / 2; j++) begin
                if (j < (WIDTH >> k)) begin
                    w_m_c0[k][j] = w_src_c0[k-1][2*j]
                                 ? w_src_c1[k-1][2*j+1] : w_src_c0[k-1][2*j+1];
                    w_m_c1[k][j] = w_src_c1[k-1][2*j]
                                 ? w_src_c1[k-1][2*j+1] : w_src_c0[k-1][2*j+1];
                end
            end
        end
    end

    // Final resolution with the bundle's real carry-in.
    always_comb begin
        w_res_sum  = w_src_cin[c_levels-1] ? w_m_sum1[c_levels] : w_m_sum0[c_levels];
        w_res_cout = w_src_cin[c_levels-1] ? w_m_c1[c_levels][0] : w_m_c0[c_levels][0];
    end

    // ------------------------------------------------------------------------
    // Ready chain: a level loads when it is empty or its successor loads, so
    // bubbles collapse and in_ready follows out_ready combinationally.
    // ------------------------------------------------------------------------
    always_comb begin
        w_load           = '0;
        w_load[c_levels] = !r_valid[c_levels] || bus.out_ready;
        for (int k = c_levels - 1; k >= 1; k--) begin
            w_load[k] = !r_valid[k] || w_load[k+1];
        end
    end

    assign w_accept    = bus.in_valid && w_load[1];
    // Legal cells always have s1 == ~s0 and never carry with cin=0 but not
    // with cin=1.
    assign w_violation = (|(~(bus.s0_i ^ bus.s1_i))) || (|(bus.c0_i & ~bus.c1_i));

    // ------------------------------------------------------------------------
    // Pipeline registers. Data only moves when the source holds a valid
    // bundle, so sum_o/cout_o keep the last result once the pipe drains.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            for (int k = 1; k < c_levels; k++) begin
                r_sum0[k] <= '0;
                r_sum1[k] <= '0;
                r_c0[k]   <= '0;
                r_c1[k]   <= '0;
                r_cin[k]  <= 1'b0;
            end
        end else begin
            for (int k = 1; k <= c_levels; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= w_src_valid[k-1];
                end
            end
            for (int k = 1; k < c_levels; k++) begin
                if (w_load[k] && w_src_valid[k-1]) begin
                    r_sum0[k] <= w_m_sum0[k];
                    r_sum1[k] <= w_m_sum1[k];
                    r_c0[k]   <= w_m_c0[k];
                    r_c1[k]   <= w_m_c1[k];
                    r_cin[k]  <= w_src_cin[k-1];
                end
            end
            if (w_load[c_levels] && w_src_valid[c_levels-1]) begin
                r_sum  <= w_res_sum;
                r_cout <= w_res_cout;
            end
            if (w_accept && w_violation) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = w_load[1];
    assign bus.out_valid = r_valid[c_levels];
    assign bus.sum_o     = r_sum;
    assign bus.cout_o    = r_cout;
    assign bus.err_o     = r_err;

endmodule
`default_nettype wire
